// File: rtl/engine_pkg.sv
// engine_pkg: op codes, FSM encoding and saturation helper
// shared by conv_lane_engine and lane_alu.
package engine_pkg;

   localparam logic [2:0] OP_CONV  = 3'd1;
   localparam logic [2:0] OP_MPOOL = 3'd4;
   localparam logic [2:0] OP_APOOL = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMPUTE,
      S_WB,
      S_DONE
   } state_t;

   function automatic logic op_ok(input logic [2:0] op);
      return (op == OP_CONV) || (op == OP_MPOOL) || (op == OP_APOOL);
   endfunction

   // Clamp a sign-extended value into a dw-bit signed range.
   function automatic logic signed [63:0] sat(
      input logic signed [63:0] v,
      input int                 dw
   );
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/lane_alu.sv
// lane_alu: one accumulator lane; multiply-accumulate,
// running max or running sum selected by mode.
module lane_alu
   import engine_pkg::*;
#(
   parameter int DW   = 16,
   parameter int ACCW = 40
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   en,
   input  logic [2:0]             mode,
   input  logic signed [DW-1:0]   d,
   input  logic signed [DW-1:0]   w,
   output logic signed [ACCW-1:0] acc
);

   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [ACCW-1:0] prod_x, d_x, init;
   logic signed [2*DW-1:0] prod;

   assign prod   = d * w;
   assign prod_x = {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
   assign d_x    = {{(ACCW-DW){d[DW-1]}}, d};
   // Max-pool starts from the most negative word so any sample wins.
   assign init   = (mode == OP_MPOOL) ?
                   {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}} : '0;

   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = init;
      end else if (en) begin
         case (mode)
            OP_CONV:  acc_d = acc_q + prod_x;
            OP_MPOOL: if (d_x > acc_q) acc_d = d_x;
            OP_APOOL: acc_d = acc_q + d_x;
            default:  acc_d = acc_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/conv_lane_engine.sv
// conv_lane_engine: chunked lane-parallel conv/pool engine on DMA p2/p3/p0.
// Define ENGINE_PERF_CNT_EN to add perf_cycles/perf_stall outputs.
module conv_lane_engine
   import engine_pkg::*;
#(
   parameter int LANES = 16,
   parameter int DW    = 16,
   parameter int ACCW  = 40,
   parameter int FRAC  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          engine_valid,
   input  logic [2:0]    op_type,
   input  logic [31:0]   op_num,
   input  logic [7:0]    i_channel,
   input  logic [31:0]   data_start_addr,
   input  logic [31:0]   weight_start_addr,
   input  logic [31:0]   result_start_addr,
   output logic          engine_ready,
   output logic          engine_err,
   output logic          dma_p2_reads_en,
   output logic [29:0]   p2_addr,
   output logic          dma_p3_reads_en,
   output logic [29:0]   p3_addr,
   input  logic [DW-1:0] dma_p2_ob_data,
   input  logic          dma_p2_ob_we,
   input  logic [DW-1:0] dma_p3_ob_data,
   input  logic          dma_p3_ob_we,
   output logic          dma_p0_writes_en,
   output logic [29:0]   p0_addr,
   input  logic          dma_p0_ib_re,
   output logic [DW-1:0] dma_p0_ib_data,
   output logic          dma_p0_ib_valid
`ifdef ENGINE_PERF_CNT_EN
   ,
   output logic [31:0]   perf_cycles,
   output logic [31:0]   perf_stall
`endif
);

   localparam int CW = $clog2(LANES + 1);

   state_t        state_q, state_d;
   logic [2:0]    op_q, op_d;
   logic [31:0]   num_q, num_d, cnt_q, cnt_d;
   logic [CW-1:0] para_q, para_d, n2_q, n2_d, n3_q, n3_d, wn_q, wn_d;
   logic [29:0]   a2_q, a2_d, a3_q, a3_d, a0_q, a0_d;
   logic          err_q, err_d, vld_q, vld_d;
   logic [DW-1:0] dv_q, dv_d;
   logic [DW-1:0] dbuf_q [LANES];
   logic [DW-1:0] wbuf_q [LANES];
   logic signed [ACCW-1:0] acc_w [LANES];

   logic          start, bad, conv, clr, cmp;
   logic          done2, done3, take2, take3;
   logic [31:0]   rem, sum;
   logic [CW-1:0] chunk;
   logic [2:0]    mode;
   logic signed [ACCW-1:0] sel, shr;
   logic [63:0]   sat_c, sat_a;
   logic [DW-1:0] res;
   logic          unused_bits;

   assign start = (state_q == S_IDLE) && engine_valid;
   assign bad   = !op_ok(op_type) || (i_channel == '0) || (op_num == '0);
   assign conv  = (op_q == OP_CONV);
   assign rem   = num_q - cnt_q;
   assign chunk = (rem < 32'(para_q)) ? rem[CW-1:0] : para_q;
   assign sum   = cnt_q + 32'(chunk);
   assign done2 = (n2_q == chunk);
   assign done3 = !conv || (n3_q == chunk);
   assign take2 = (state_q == S_LOAD) && dma_p2_ob_we && !done2;
   assign take3 = (state_q == S_LOAD) && dma_p3_ob_we && !done3;
   assign clr   = start && !bad;
   assign cmp   = (state_q == S_COMPUTE);
   // Lanes must see the incoming op while clearing, before it is latched.
   assign mode  = start ? op_type : op_q;

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (engine_valid) state_d = bad ? S_DONE : S_LOAD;
         S_LOAD:    if (done2 && done3) state_d = S_COMPUTE;
         S_COMPUTE: state_d = (sum >= num_q) ? S_WB : S_LOAD;
         S_WB:      if (wn_q == para_q) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dma_p2_reads_en  = 1'b0;
      dma_p3_reads_en  = 1'b0;
      dma_p0_writes_en = 1'b0;
      engine_ready     = 1'b0;
      unique case (state_q)
         S_LOAD: begin
            dma_p2_reads_en = !done2;
            dma_p3_reads_en = !done3;
         end
         S_WB:    dma_p0_writes_en = (wn_q != para_q);
         S_DONE:  engine_ready = 1'b1;
         default: ;
      endcase
      p2_addr = dma_p2_reads_en  ? a2_q : '0;
      p3_addr = dma_p3_reads_en  ? a3_q : '0;
      p0_addr = dma_p0_writes_en ? a0_q : '0;
   end

   always_comb begin
      op_d   = op_q;
      num_d  = num_q;
      para_d = para_q;
      cnt_d  = cnt_q;
      a2_d   = a2_q;
      a3_d   = a3_q;
      a0_d   = a0_q;
      n2_d   = n2_q;
      n3_d   = n3_q;
      wn_d   = wn_q;
      err_d  = err_q;
      dv_d   = dv_q;
      vld_d  = 1'b0;
      if (start) begin
         err_d = bad;
         if (!bad) begin
            op_d   = op_type;
            num_d  = op_num;
            para_d = (i_channel < 8'(LANES)) ? CW'(i_channel) : CW'(LANES);
            cnt_d  = '0;
            a2_d   = data_start_addr[29:0];
            a3_d   = weight_start_addr[29:0];
            a0_d   = result_start_addr[29:0];
            n2_d   = '0;
            n3_d   = '0;
            wn_d   = '0;
         end
      end
      if (take2) n2_d = n2_q + 1'b1;
      if (take3) n3_d = n3_q + 1'b1;
      if (cmp) begin
         cnt_d = sum;
         a2_d  = a2_q + 30'(chunk);
         a3_d  = a3_q + 30'(chunk);
         n2_d  = '0;
         n3_d  = '0;
      end
      if ((state_q == S_WB) && dma_p0_ib_re && (wn_q != para_q)) begin
         dv_d  = res;
         vld_d = 1'b1;
         wn_d  = wn_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q   <= '0;
         num_q  <= '0;
         para_q <= '0;
         cnt_q  <= '0;
         a2_q   <= '0;
         a3_q   <= '0;
         a0_q   <= '0;
         n2_q   <= '0;
         n3_q   <= '0;
         wn_q   <= '0;
         err_q  <= 1'b0;
         dv_q   <= '0;
         vld_q  <= 1'b0;
      end else begin
         op_q   <= op_d;
         num_q  <= num_d;
         para_q <= para_d;
         cnt_q  <= cnt_d;
         a2_q   <= a2_d;
         a3_q   <= a3_d;
         a0_q   <= a0_d;
         n2_q   <= n2_d;
         n3_q   <= n3_d;
         wn_q   <= wn_d;
         err_q  <= err_d;
         dv_q   <= dv_d;
         vld_q  <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (rst) begin
            dbuf_q[k] <= '0;
            wbuf_q[k] <= '0;
         end else begin
            if (take2 && (n2_q == CW'(k))) dbuf_q[k] <= dma_p2_ob_data;
            if (take3 && (n3_q == CW'(k))) wbuf_q[k] <= dma_p3_ob_data;
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      lane_alu #(
         .DW   (DW),
         .ACCW (ACCW)
      ) u_alu (
         .clk   (clk),
         .rst   (rst),
         .clear (clr),
         .en    (cmp && (CW'(k) < chunk)),
         .mode  (mode),
         .d     (dbuf_q[k]),
         .w     (wbuf_q[k]),
         .acc   (acc_w[k])
      );
   end

   always_comb begin
      sel = '0;
      for (int k = 0; k < LANES; k++) begin
         if (wn_q == CW'(k)) sel = acc_w[k];
      end
      shr   = sel >>> FRAC;
      sat_c = sat({{(64-ACCW){shr[ACCW-1]}}, shr}, DW);
      sat_a = sat({{(64-ACCW){sel[ACCW-1]}}, sel}, DW);
      unique case (op_q)
         OP_CONV:  res = sat_c[DW-1:0];
         OP_APOOL: res = sat_a[DW-1:0];
         default:  res = sel[DW-1:0];
      endcase
   end

   assign engine_err      = err_q;
   assign dma_p0_ib_data  = dv_q;
   assign dma_p0_ib_valid = vld_q;

   assign unused_bits = ^{data_start_addr[31:30], weight_start_addr[31:30],
                          result_start_addr[31:30], sat_c[63:DW], sat_a[63:DW]};

`ifdef ENGINE_PERF_CNT_EN
   logic [31:0] pc_q, pc_d, ps_q, ps_d;

   always_comb begin
      pc_d = pc_q;
      ps_d = ps_q;
      if (start) begin
         pc_d = '0;
         ps_d = '0;
      end else if (state_q inside {S_LOAD, S_COMPUTE, S_WB}) begin
         pc_d = pc_q + 32'd1;
      end
      if ((state_q == S_LOAD) && !(dma_p2_ob_we || (conv && dma_p3_ob_we)))
         ps_d = ps_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
         ps_q <= '0;
      end else begin
         pc_q <= pc_d;
         ps_q <= ps_d;
      end
   end

   assign perf_cycles = pc_q;
   assign perf_stall  = ps_q;
`endif

endmodule
